// File: rtl/digit_serial_addsub.sv
// -----------------------------------------------------------------------------
// digit_serial_addsub
//
// Multi-cycle add/subtract unit for wide operands. It computes a+b+cin or
// a-b-cin over WIDTH bits, handling DIGIT bits per clock, LSB digit first.
// The carry/borrow chain is held in a flop between digits. After the last
// digit, the unit reports the following:
//   - the result, wrapped or saturated on signed overflow
//   - the raw carry/borrow-out
//   - signed overflow
//   - a zero flag
//
// Sequence: IDLE -> RUN (NDIG cycles, one digit each) -> DONE (1 cycle) -> IDLE.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (wins over everything)
//   start     request, accepted only in IDLE
//   op_sub    0: a+b+cin, 1: a-b-cin            (sampled with start)
//   sat_en    clamp result on signed overflow   (sampled with start)
//   a, b      WIDTH-bit operands                (sampled with start)
//   cin       carry-in (add) / borrow-in (sub)  (sampled with start)
//   busy      high in RUN and DONE
//   done      one-cycle pulse; result/flags valid from this cycle
//   result    final result (post-saturation)
//   cout      carry-out (add) / borrow-out (sub), never saturated
//   overflow  signed overflow of the true result
//   zero      result == 0 (after saturation)
// -----------------------------------------------------------------------------
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic             sat_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Operand shift registers: the current digit always sits in the low DIGIT bits.
    // B is stored already inverted for subtraction, so the datapath is a plain adder.
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op_sub;
    logic             r_sat_en;
    logic             r_a_msb;     // sign of A
    logic             r_b_msb;     // sign of the effective addend (B or ~B)

    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_overflow;
    logic             r_zero;

    logic [DIGIT-1:0] w_a_d;
    logic [DIGIT-1:0] w_b_d;
    logic [DIGIT:0]   w_digit_full;
    logic [DIGIT-1:0] w_digit_sum;
    logic             w_digit_c;
    logic [WIDTH-1:0] w_a_sh_next;
    logic [WIDTH-1:0] w_b_sh_next;
    logic [WIDTH-1:0] w_sum_final;
    logic             w_last;
    logic             w_raw_ov;
    logic [WIDTH-1:0] w_sat_value;
    logic [WIDTH-1:0] w_final_result;
    logic             w_final_cout;

    // ---------------------------------------------------------------- datapath
    assign w_a_d        = r_a_sh[DIGIT-1:0];
    assign w_b_d        = r_b_sh[DIGIT-1:0];
    assign w_digit_full = {1'b0, w_a_d} + {1'b0, w_b_d} + {{DIGIT{1'b0}}, r_carry};
    assign w_digit_sum  = w_digit_full[DIGIT-1:0];
    assign w_digit_c    = w_digit_full[DIGIT];
    assign w_last       = (r_cnt == LAST_CNT);

    generate
        if (NDIG == 1) begin : g_single
            assign w_a_sh_next = '0;
            assign w_b_sh_next = '0;
        end else begin : g_multi
            assign w_a_sh_next = {{DIGIT{1'b0}}, r_a_sh[WIDTH-1:DIGIT]};
            assign w_b_sh_next = {{DIGIT{1'b0}}, r_b_sh[WIDTH-1:DIGIT]};
        end
    endgenerate

    // The partial sum is assembled in place.
    // The digit being processed this cycle is spliced into its slot, so on the
    // last RUN cycle w_sum_final is the complete wrapped sum.
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_sum_dig
            assign w_sum_final[gi*DIGIT +: DIGIT] =
                (r_cnt == CNT_W'(gi)) ? w_digit_sum : r_sum[gi*DIGIT +: DIGIT];
        end
    endgenerate

    // Subtraction runs as A + ~B + ~borrow_in.
    // This is an exact two's-complement addition of two WIDTH-bit signed values
    // plus a carry, so overflow is "same input signs, different result sign".
    assign w_raw_ov       = (r_a_msb == r_b_msb) && (w_sum_final[WIDTH-1] != r_a_msb);
    assign w_sat_value    = r_a_msb ? MOST_NEG : MOST_POS;
    assign w_final_result = (r_sat_en && w_raw_ov) ? w_sat_value : w_sum_final;
    // The inverted-borrow chain yields carry=1 when no borrow occurred.
    assign w_final_cout   = r_op_sub ? ~w_digit_c : w_digit_c;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_op_sub   <= 1'b0;
            r_sat_en   <= 1'b0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= op_sub ? ~b : b;
                        r_sum    <= '0;
                        r_carry  <= op_sub ? ~cin : cin;
                        r_cnt    <= '0;
                        r_op_sub <= op_sub;
                        r_sat_en <= sat_en;
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= op_sub ? ~b[WIDTH-1] : b[WIDTH-1];
                    end
                end
                S_RUN: begin
                    r_a_sh  <= w_a_sh_next;
                    r_b_sh  <= w_b_sh_next;
                    r_sum   <= w_sum_final;
                    r_carry <= w_digit_c;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Outputs change only on the edge that enters DONE.
                    if (w_last) begin
                        r_result   <= w_final_result;
                        r_cout     <= w_final_cout;
                        r_overflow <= w_raw_ov;
                        r_zero     <= (w_final_result == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_overflow;
    assign zero     = r_zero;

endmodule
